// File: rtl/time_display_pager_if.sv
// Bus between the time counter side and the display pager: BCD fields and
// operator controls flow in, segment drives and the page indicator flow out.
interface time_display_pager_if;
    logic       adjust;
    logic [3:0] select;
    logic       page_key;
    logic [7:0] millisecond;
    logic [6:0] second;
    logic [6:0] minute;
    logic [5:0] hour;
    logic [5:0] day;
    logic [4:0] month;
    logic [7:0] year_l;
    logic [7:0] year_h;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
    logic       page_led;

    modport master (
        output adjust, select, page_key,
        output millisecond, second, minute, hour, day, month, year_l, year_h,
        input  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7, page_led
    );

    modport slave (
        input  adjust, select, page_key,
        input  millisecond, second, minute, hour, day, month, year_l, year_h,
        output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7, page_led
    );
endinterface

// File: rtl/time_display_pager.sv
// Filters the ripple-clocked BCD time/date fields and pages them onto the eight
// seven-segment displays, blinking the digit under adjustment. Optional macro
// TIME_PAGE_AUTO_EN adds a periodic automatic page flip while the clock runs.
module time_display_pager #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BLINK_HALF      = 12_500_000,
    parameter int AUTO_CYCLES     = 200_000_000
) (
    input logic                 CLOCK_50,
    input logic                 month_low_clrin,
    time_display_pager_if.slave bus
);
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BLK_W = $clog2(BLINK_HALF + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_HALF - 1);

    typedef struct packed {
        logic [7:0] millisecond;
        logic [6:0] second;
        logic [6:0] minute;
        logic [5:0] hour;
        logic [5:0] day;
        logic [4:0] month;
        logic [7:0] year_l;
        logic [7:0] year_h;
    } fields_t;

    fields_t          s1, s2, disp;
    logic             disp_valid;
    logic             key_meta, key_sync, key_acc, key_acc_d;
    logic             key_rise;
    logic [DEB_W-1:0] deb_cnt;
    logic [BLK_W-1:0] blink_cnt;
    logic             blink_on;
    logic [3:0]       select_d;
    logic             page;
    logic [3:0]       digit [8];
    logic [6:0]       hex_r [8];

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Only a snapshot seen identically on two consecutive cycles is trusted,
    // so mid-ripple counter values never reach the display.
    always_ff @(posedge CLOCK_50 or posedge month_low_clrin) begin
        if (month_low_clrin) begin
            s1         <= '0;
            s2         <= '0;
            disp       <= '0;
            disp_valid <= 1'b0;
        end else begin
            s1 <= {bus.millisecond, bus.second, bus.minute, bus.hour,
                   bus.day, bus.month, bus.year_l, bus.year_h};
            s2 <= s1;
            if (s1 == s2) begin
                disp       <= s2;
                disp_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge month_low_clrin) begin
        if (month_low_clrin) begin
            key_meta  <= 1'b0;
            key_sync  <= 1'b0;
            key_acc   <= 1'b0;
            key_acc_d <= 1'b0;
            deb_cnt   <= '0;
        end else begin
            key_meta  <= bus.page_key;
            key_sync  <= key_meta;
            key_acc_d <= key_acc;
            if (key_sync == key_acc) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                key_acc <= key_sync;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    assign key_rise = key_acc & ~key_acc_d;

    // A new select restarts the blink in its visible phase.
    always_ff @(posedge CLOCK_50 or posedge month_low_clrin) begin
        if (month_low_clrin) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
            select_d  <= 4'd0;
        end else begin
            select_d <= bus.select;
            if (bus.adjust || (bus.select != select_d)) begin
                blink_cnt <= '0;
                blink_on  <= 1'b1;
            end else if (blink_cnt == BLK_LAST) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

`ifdef TIME_PAGE_AUTO_EN
    localparam int AUTO_W = $clog2(AUTO_CYCLES + 1);
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_CYCLES - 1);
    logic [AUTO_W-1:0] auto_cnt;
    logic              auto_flip;

    always_ff @(posedge CLOCK_50 or posedge month_low_clrin) begin
        if (month_low_clrin) begin
            auto_cnt <= '0;
        end else if (!bus.adjust || key_rise || (auto_cnt == AUTO_LAST)) begin
            auto_cnt <= '0;
        end else begin
            auto_cnt <= auto_cnt + 1'b1;
        end
    end

    assign auto_flip = (auto_cnt == AUTO_LAST);
`else
    logic auto_flip;
    assign auto_flip = 1'b0;
`endif

    // Adjust mode pins the page holding the selected digit; keys are ignored then.
    always_ff @(posedge CLOCK_50 or posedge month_low_clrin) begin
        if (month_low_clrin) begin
            page <= 1'b0;
        end else if (!bus.adjust) begin
            page <= bus.select[3];
        end else if (key_rise || auto_flip) begin
            page <= ~page;
        end
    end

    always_comb begin
        if (page) begin
            digit[0] = disp.day[3:0];
            digit[1] = {2'b00, disp.day[5:4]};
            digit[2] = disp.month[3:0];
            digit[3] = {3'b000, disp.month[4]};
            digit[4] = disp.year_l[3:0];
            digit[5] = disp.year_l[7:4];
            digit[6] = disp.year_h[3:0];
            digit[7] = disp.year_h[7:4];
        end else begin
            digit[0] = disp.millisecond[3:0];
            digit[1] = disp.millisecond[7:4];
            digit[2] = disp.second[3:0];
            digit[3] = {1'b0, disp.second[6:4]};
            digit[4] = disp.minute[3:0];
            digit[5] = {1'b0, disp.minute[6:4]};
            digit[6] = disp.hour[3:0];
            digit[7] = {2'b00, disp.hour[5:4]};
        end
    end

    always_ff @(posedge CLOCK_50 or posedge month_low_clrin) begin
        if (month_low_clrin) begin
            for (int i = 0; i < 8; i++) hex_r[i] <= 7'h7F;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (!disp_valid ||
                    (!bus.adjust && !blink_on && (bus.select[2:0] == 3'(i))))
                    hex_r[i] <= 7'h7F;
                else
                    hex_r[i] <= seg7(digit[i]);
            end
        end
    end

    assign bus.HEX0     = hex_r[0];
    assign bus.HEX1     = hex_r[1];
    assign bus.HEX2     = hex_r[2];
    assign bus.HEX3     = hex_r[3];
    assign bus.HEX4     = hex_r[4];
    assign bus.HEX5     = hex_r[5];
    assign bus.HEX6     = hex_r[6];
    assign bus.HEX7     = hex_r[7];
    assign bus.page_led = page;
endmodule

// File: doc/time_display_pager.md
# time_display_pager

- Reads the BCD time/date fields produced by the time counter and drives the eight DE2 seven-segment displays.
- Registers the fields through a stability filter, because the ripple-clocked counters change asynchronously to CLOCK_50.
- Shows one of two 8-digit pages (time or date) and blinks the digit currently chosen by `select` while the clock is being adjusted.
- Sits in the top level, between the time counter and the HEX pins.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1_000_000 — cycles page_key must stay stable to be accepted (20 ms).
- BLINK_HALF, 12_500_000 — cycles per blink phase (2 Hz blink).
- AUTO_CYCLES, 200_000_000 — auto page period (4 s), used only with the macro in Configuration.

Ports:
- CLOCK_50  in  1  system clock
- month_low_clrin  in  1  reset, asynchronous, active-high
- adjust  in  1  1 = clock running, 0 = adjust mode
- select  in  4  digit being adjusted: 0 = ms low … 15 = year thousands
- page_key  in  1  page button, active-high (already inverted at top), asynchronous
- millisecond  in  8  BCD
- second  in  7  BCD
- minute  in  7  BCD
- hour  in  6  BCD
- day  in  6  BCD
- month  in  5  BCD
- year_l  in  8  BCD
- year_h  in  8  BCD
- HEX0..HEX7  out  7 each  segments, active-low, bit0 = a … bit6 = g
- page_led  out  1  current page: 0 = time, 1 = date

## Operation
- Snapshot filter:
  - The 55 field bits are concatenated into s1 every cycle; s2 <= s1.
  - The display register loads s2 only when s1 == s2, so a field that toggles every cycle never reaches the display.
- Digit map, time page, HEX7..HEX0: hour[5:4], hour[3:0], minute[6:4], minute[3:0], second[6:4], second[3:0], millisecond[7:4], millisecond[3:0]. Narrow fields are zero-extended to 4 bits.
- Digit map, date page, HEX7..HEX0: year_h[7:4], year_h[3:0], year_l[7:4], year_l[3:0], month[4], month[3:0], day[5:4], day[3:0].
- Consequence of the two maps: digit `select` is always on page select[3] at position HEX[select[2:0]].
- Decode table: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 (hex). Codes 10–15 and blanked digits output 7F.
- Page key handling:
  - 2-flop synchronizer, then a debounce counter that reloads whenever the synchronized level differs from the accepted level.
  - The accepted level updates after DEBOUNCE_CYCLES stable cycles.
  - An accepted 0→1 transition toggles the page, but only while adjust = 1.
- Adjust mode (adjust = 0):
  - The page is forced to select[3] and key presses are ignored.
  - The digit at HEX[select[2:0]] blinks. blink_on toggles every BLINK_HALF cycles, and the digit outputs 7F while blink_on = 0.
  - A change of select restarts the blink with blink_on = 1, so the newly selected digit is shown immediately.
- Run mode (adjust = 1):
  - The blink counter is held at 0 and blink_on at 1.
  - The page keeps its last value, including the value forced during adjust mode.

## Timing
- Reset values: HEX0..HEX7 = 7F, page_led = 0, blink_on = 1. All counters, s1, s2 and the display register are 0.
- Release from reset: HEX outputs stay 7F until the first display-register load.
- Latency from a field change held stable to HEX: 4 cycles (s1, s2, display register, output register). All outputs are registered.
- Key latency from page_key rise to page_led toggle: 2 + DEBOUNCE_CYCLES + 1 cycles.
- adjust 1→0: page = select[3] on the next cycle and HEX on the cycle after; the blink starts in the on phase.
- Reset mid-debounce or mid-blink: all state returns immediately to the reset values.
- A key accepted in the same cycle as adjust falls to 0 is ignored.

## Configuration
- Macro: TIME_PAGE_AUTO_EN.
- Defined:
  - While adjust = 1, a counter toggles the page every AUTO_CYCLES cycles.
  - An accepted key press toggles the page and clears the counter.
  - The counter is held at 0 while adjust = 0.
- Undefined: the page changes only on key presses and in adjust mode. The counter logic is not built.

## Test plan
Benches override the parameters to DEBOUNCE_CYCLES = 8, BLINK_HALF = 16, AUTO_CYCLES = 64.
- Reset, then adjust = 1 with hour = 6'h23, minute = 7'h59, second = 7'h58, millisecond = 8'h07 → after 4 cycles HEX7..HEX0 = 24,30,12,10,12,00,40,78 and page_led = 0.
- page_key held high for 10 cycles → page_led = 1, and year 2024 / month 02 / day 29 shows HEX7..HEX0 = 24,40,24,19,40,24,24,10. A 5-cycle pulse (shorter than DEBOUNCE_CYCLES) → no toggle.
- adjust = 0, select = 4'd10 → page_led = 1, and HEX2 alternates 24/7F every 16 cycles while the other digits stay steady. select → 3 → page_led = 0 and HEX3 is visible on the next update.
- millisecond toggling between 8'h00 and 8'h01 every cycle → HEX0/HEX1 never change. Holding 8'h01 → HEX0 = 79 four cycles later.
- Reset asserted mid-blink → all HEX = 7F and page_led = 0 in the same cycle. With TIME_PAGE_AUTO_EN: adjust = 1 with no key → page_led toggles every 64 cycles.
